// File: rtl/oled_serial_win.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : oled_serial_win                                                |
// | Brief   : Byte-serial OLED frame streamer (SSD1306 / SH1106) with dirty  |
// |           window updates and runtime contrast / invert / on-off.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module oled_serial_win #(
    parameter int         MAIN_CLK      = 50_000_000,
    parameter int         BUS_BITS      = 8,
    parameter int         SCREEN_WIDTH  = 128,
    parameter int         SCREEN_HEIGHT = 64,
    parameter int         CTRL_TYPE     = 0,
    parameter int         COL_OFFS      = 0,
    parameter int         WAIT_RESET    = MAIN_CLK / 50,
    parameter int         WAIT_UPDATE   = MAIN_CLK / 20,
    parameter logic [7:0] CONTRAST      = 8'hff,
    parameter int         SCREEN_PAGES  = SCREEN_HEIGHT / BUS_BITS,
    parameter int         HCTR_BITS     = $clog2(SCREEN_WIDTH),
    parameter int         VCTR_BITS     = $clog2(SCREEN_HEIGHT),
    parameter int         PAGE_BITS     = $clog2(SCREEN_PAGES)
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_update,
    input  logic [HCTR_BITS-1:0] in_x0,
    input  logic [HCTR_BITS-1:0] in_x1,
    input  logic [PAGE_BITS-1:0] in_p0,
    input  logic [PAGE_BITS-1:0] in_p1,
    input  logic [7:0]           in_contrast,
    input  logic                 in_set_contrast,
    input  logic                 in_invert,
    input  logic                 in_disp_on,
    input  logic [BUS_BITS-1:0]  in_pixels,
    output logic [HCTR_BITS-1:0] out_hpix,
    output logic [VCTR_BITS-1:0] out_vpix,
    output logic [PAGE_BITS-1:0] out_vpage,
    output logic                 out_busy,
    output logic                 out_frame_done,
    input  logic                 in_bus_ready,
    input  logic                 in_bus_next_word,
    output logic                 out_bus_enable,
    output logic [BUS_BITS-1:0]  out_bus_data
);

    localparam int c_ROW_BITS = VCTR_BITS - PAGE_BITS;
    // Timer covers one second or the longest wait, whichever is larger.
    localparam int c_TMR_MAX  = (MAIN_CLK > WAIT_RESET) ?
                                ((MAIN_CLK > WAIT_UPDATE) ? MAIN_CLK : WAIT_UPDATE) :
                                ((WAIT_RESET > WAIT_UPDATE) ? WAIT_RESET : WAIT_UPDATE);
    localparam int c_TMR_BITS = $clog2(c_TMR_MAX + 1);
    localparam logic [HCTR_BITS-1:0] c_X_MAX = HCTR_BITS'(SCREEN_WIDTH - 1);
    localparam logic [PAGE_BITS-1:0] c_P_MAX = PAGE_BITS'(SCREEN_PAGES - 1);
    localparam logic [7:0] c_COL_OFFS = 8'(COL_OFFS);

    localparam logic [3:0] S_RESET     = 4'd0;
    localparam logic [3:0] S_INIT      = 4'd1;
    localparam logic [3:0] S_WAIT_IDLE = 4'd2;
    localparam logic [3:0] S_IDLE      = 4'd3;
    localparam logic [3:0] S_SETTING   = 4'd4;
    localparam logic [3:0] S_FRAME_CMD = 4'd5;
    localparam logic [3:0] S_PAGE_CMD  = 4'd6;
    localparam logic [3:0] S_DATA_CMD  = 4'd7;
    localparam logic [3:0] S_DATA      = 4'd8;
    localparam logic [3:0] S_WAIT_DONE = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;

    localparam logic [1:0] c_SEL_CON = 2'd0;
    localparam logic [1:0] c_SEL_INV = 2'd1;
    localparam logic [1:0] c_SEL_ON  = 2'd2;

    logic [3:0]            r_state, w_next_state;
    logic                  r_nw_prev;
    logic [c_TMR_BITS-1:0] r_tmr;
    logic [4:0]            r_idx;
    logic [HCTR_BITS-1:0]  r_col, r_x0, r_x1;
    logic [PAGE_BITS-1:0]  r_page, r_p0, r_p1;
    logic                  r_pend_upd, r_pend_con, r_sent_inv, r_sent_on;
    logic [1:0]            r_set_sel;
    logic [7:0]            r_set_val;

    logic                  w_bus_cycle, w_pend_inv, w_pend_on, w_set_any, w_frame_go;
    logic                  w_start, w_set_last, w_set_done, w_cmd_state;
    logic                  w_col_last, w_page_last, w_win_bad;
    logic [HCTR_BITS-1:0]  w_x1c, w_x0s, w_x1s;
    logic [PAGE_BITS-1:0]  w_p1c, w_p0s, w_p1s;
    logic [7:0]            w_colb, w_cmd;

    function automatic logic [7:0] f_init_byte(input logic [4:0] idx);
        case (idx)
            5'd0:  f_init_byte = 8'h80;  5'd1:  f_init_byte = 8'hAE;
            5'd2:  f_init_byte = 8'h00;  5'd3:  f_init_byte = 8'hD5;
            5'd4:  f_init_byte = 8'hF0;  5'd5:  f_init_byte = 8'h00;
            5'd6:  f_init_byte = 8'hA8;  5'd7:  f_init_byte = 8'(SCREEN_HEIGHT - 1);
            5'd8:  f_init_byte = 8'h00;  5'd9:  f_init_byte = 8'h20;
            5'd10: f_init_byte = 8'h00;  5'd11: f_init_byte = 8'h80;
            5'd12: f_init_byte = 8'hA1;  5'd13: f_init_byte = 8'h80;
            5'd14: f_init_byte = 8'hC8;  5'd15: f_init_byte = 8'h00;
            5'd16: f_init_byte = 8'hD3;  5'd17: f_init_byte = 8'h00;
            5'd18: f_init_byte = 8'h00;  5'd19: f_init_byte = 8'h81;
            5'd20: f_init_byte = CONTRAST; 5'd21: f_init_byte = 8'h80;
            5'd22: f_init_byte = 8'hA6;  5'd23: f_init_byte = 8'h00;
            5'd24: f_init_byte = 8'h8D;  5'd25: f_init_byte = 8'h14;
            5'd26: f_init_byte = 8'h80;  5'd27: f_init_byte = 8'hAF;
            5'd28: f_init_byte = 8'h80;  5'd29: f_init_byte = 8'hA4;
            default: f_init_byte = 8'h00;
        endcase
    endfunction

    assign w_bus_cycle = in_bus_next_word & ~r_nw_prev;
    // Invert / on-off are pending whenever the level differs from what the panel last received.
    assign w_pend_inv  = in_invert ^ r_sent_inv;
    assign w_pend_on   = in_disp_on ^ r_sent_on;
    assign w_set_any   = r_pend_con | w_pend_inv | w_pend_on;
    assign w_frame_go  = r_pend_upd && (r_tmr >= c_TMR_BITS'(WAIT_UPDATE));
    assign w_start     = (r_state == S_IDLE) && !w_set_any && w_frame_go;
    assign w_set_last  = (r_set_sel == c_SEL_CON) ? (r_idx == 5'd3) : (r_idx == 5'd1);
    assign w_set_done  = (r_state == S_SETTING) && w_bus_cycle && w_set_last;
    assign w_cmd_state = (r_state == S_INIT) || (r_state == S_SETTING) ||
                         (r_state == S_FRAME_CMD) || (r_state == S_PAGE_CMD);
    assign w_col_last  = (r_col == r_x1);
    assign w_page_last = (r_page == r_p1);

    assign w_x1c     = (32'(in_x1) > 32'(SCREEN_WIDTH - 1)) ? c_X_MAX : in_x1;
    assign w_p1c     = (32'(in_p1) > 32'(SCREEN_PAGES - 1)) ? c_P_MAX : in_p1;
    assign w_win_bad = (in_x0 > w_x1c) || (in_p0 > w_p1c);
    assign w_x0s     = w_win_bad ? '0      : in_x0;
    assign w_x1s     = w_win_bad ? c_X_MAX : w_x1c;
    assign w_p0s     = w_win_bad ? '0      : in_p0;
    assign w_p1s     = w_win_bad ? c_P_MAX : w_p1c;
    assign w_colb    = 8'(r_x0) + c_COL_OFFS;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) r_state <= S_RESET;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET:     if (r_tmr >= c_TMR_BITS'(WAIT_RESET)) w_next_state = S_INIT;
            S_INIT:      if (w_bus_cycle && r_idx == 5'd29) w_next_state = S_WAIT_IDLE;
            S_WAIT_IDLE: if (in_bus_ready) w_next_state = S_IDLE;
            S_IDLE: begin
                if (w_set_any)       w_next_state = S_SETTING;
                else if (w_frame_go) w_next_state = (CTRL_TYPE == 1) ? S_PAGE_CMD : S_FRAME_CMD;
            end
            S_SETTING:   if (w_bus_cycle && w_set_last) w_next_state = S_WAIT_IDLE;
            S_FRAME_CMD: if (w_bus_cycle && r_idx == 5'd7) w_next_state = S_DATA_CMD;
            S_PAGE_CMD:  if (w_bus_cycle && r_idx == 5'd5) w_next_state = S_DATA_CMD;
            S_DATA_CMD:  if (w_bus_cycle) w_next_state = S_DATA;
            S_DATA: begin
                if (w_bus_cycle && w_col_last) begin
                    if (w_page_last)          w_next_state = S_WAIT_DONE;
                    else if (CTRL_TYPE == 1)  w_next_state = S_PAGE_CMD;
                end
            end
            S_WAIT_DONE: if (in_bus_ready) w_next_state = S_DONE;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_RESET;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_nw_prev  <= 1'b0;
            r_tmr      <= '0;
            r_idx      <= '0;
            r_col      <= '0;
            r_page     <= '0;
            r_x0       <= '0;
            r_x1       <= '0;
            r_p0       <= '0;
            r_p1       <= '0;
            r_pend_upd <= 1'b0;
            r_pend_con <= 1'b0;
            r_sent_inv <= 1'b0;
            r_sent_on  <= 1'b1;
            r_set_sel  <= c_SEL_CON;
            r_set_val  <= 8'h00;
        end else begin
            r_nw_prev  <= in_bus_next_word;
            r_pend_upd <= in_update | (r_pend_upd & ~w_start);
            r_pend_con <= in_set_contrast | (r_pend_con & ~(w_set_done && r_set_sel == c_SEL_CON));

            if ((r_state == S_RESET && w_next_state == S_INIT) || w_start)
                r_tmr <= '0;
            else if (r_tmr != c_TMR_BITS'(c_TMR_MAX))
                r_tmr <= r_tmr + 1'b1;

            if (w_next_state != r_state)
                r_idx <= '0;
            else if (w_bus_cycle && w_cmd_state)
                r_idx <= r_idx + 5'd1;

            if ((r_state == S_IDLE) && w_set_any) begin
                if (r_pend_con) begin
                    r_set_sel <= c_SEL_CON;
                    r_set_val <= in_contrast;
                end else if (w_pend_inv) begin
                    r_set_sel <= c_SEL_INV;
                    r_set_val <= {7'd0, in_invert};
                end else begin
                    r_set_sel <= c_SEL_ON;
                    r_set_val <= {7'd0, in_disp_on};
                end
            end

            if (w_set_done && r_set_sel == c_SEL_INV) r_sent_inv <= r_set_val[0];
            if (w_set_done && r_set_sel == c_SEL_ON)  r_sent_on  <= r_set_val[0];

            if (w_start) begin
                r_x0   <= w_x0s;
                r_x1   <= w_x1s;
                r_p0   <= w_p0s;
                r_p1   <= w_p1s;
                r_col  <= w_x0s;
                r_page <= w_p0s;
            end else if (r_state == S_DATA && w_bus_cycle) begin
                if (w_col_last) begin
                    r_col <= r_x0;
                    if (!w_page_last) r_page <= r_page + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cmd = 8'h00;
        case (r_state)
            S_INIT: w_cmd = f_init_byte(r_idx);
            S_SETTING: begin
                case (r_idx[1:0])
                    2'd0:    w_cmd = 8'h80;
                    2'd1:    w_cmd = (r_set_sel == c_SEL_CON) ? 8'h81 :
                                     (r_set_sel == c_SEL_INV) ? (8'hA6 | {7'd0, r_set_val[0]}) :
                                                                (8'hAE | {7'd0, r_set_val[0]});
                    2'd2:    w_cmd = 8'h80;
                    default: w_cmd = r_set_val;
                endcase
            end
            S_FRAME_CMD: begin
                case (r_idx[2:0])
                    3'd1:    w_cmd = 8'h21;
                    3'd2:    w_cmd = 8'(r_x0);
                    3'd3:    w_cmd = 8'(r_x1);
                    3'd5:    w_cmd = 8'h22;
                    3'd6:    w_cmd = 8'(r_p0);
                    3'd7:    w_cmd = 8'(r_p1);
                    default: w_cmd = 8'h00;
                endcase
            end
            S_PAGE_CMD: begin
                case (r_idx[2:0])
                    3'd1:    w_cmd = 8'hB0 | 8'(r_page);
                    3'd3:    w_cmd = {4'h0, w_colb[3:0]};
                    3'd5:    w_cmd = {4'h1, w_colb[7:4]};
                    default: w_cmd = 8'h00;
                endcase
            end
            S_DATA_CMD: w_cmd = 8'h40;
            default:    w_cmd = 8'h00;
        endcase
    end

    assign out_bus_data   = (r_state == S_DATA) ? in_pixels : BUS_BITS'(w_cmd);
    assign out_bus_enable = w_cmd_state || (r_state == S_DATA_CMD) || (r_state == S_DATA);
    assign out_busy       = (r_state == S_FRAME_CMD) || (r_state == S_PAGE_CMD) ||
                            (r_state == S_DATA_CMD) || (r_state == S_DATA) ||
                            (r_state == S_WAIT_DONE);
    assign out_frame_done = (r_state == S_DONE);
    assign out_hpix       = r_col;
    assign out_vpage      = r_page;
    assign out_vpix       = {r_page, {c_ROW_BITS{1'b0}}};

endmodule
`default_nettype wire

// File: doc/oled_serial_win.md
Name: oled_serial_win

Overview:
- Parametrised serial OLED frame streamer for SSD1306- and SH1106-class monochrome controllers.
- Sits between a pixel source (framebuffer or text renderer) and the byte-serial bus master (I2C/SPI byte engine).
- Generalises the fixed full-frame OLED driver with controller selection, runtime dirty-window (partial) updates, runtime contrast/invert/on-off commands and a queued update request.

Parameters:
- MAIN_CLK, 50_000_000, system clock in Hz.
- BUS_BITS, 8, bus word width; also pixel rows per page.
- SCREEN_WIDTH, 128, columns; max 256.
- SCREEN_HEIGHT, 64, rows; must be a multiple of BUS_BITS.
- CTRL_TYPE, 0, 0 = SSD1306 horizontal addressing; 1 = SH1106 page addressing.
- COL_OFFS, 0, column address offset (2 for 132-column SH1106 RAM).
- WAIT_RESET, MAIN_CLK/50, power-up wait cycles (20 ms).
- WAIT_UPDATE, MAIN_CLK/20, minimum cycles between frame starts (50 ms).
- CONTRAST, 8'hff, contrast value sent at init.
- Derived: SCREEN_PAGES = SCREEN_HEIGHT/BUS_BITS; HCTR_BITS, VCTR_BITS and PAGE_BITS are the clog2 of width, height and pages.

Ports:
- in_clk  in  1  clock.
- in_rst_n  in  1  asynchronous active-low reset.
- in_update  in  1  frame request pulse.
- in_x0, in_x1  in  HCTR_BITS  inclusive column window.
- in_p0, in_p1  in  PAGE_BITS  inclusive page window.
- in_contrast  in  8  runtime contrast value.
- in_set_contrast  in  1  pulse: send contrast.
- in_invert  in  1  level: display inversion.
- in_disp_on  in  1  level: panel on/off.
- in_pixels  in  BUS_BITS  column byte for (out_hpix, out_vpage).
- out_hpix  out  HCTR_BITS  current column.
- out_vpix  out  VCTR_BITS  out_vpage*BUS_BITS.
- out_vpage  out  PAGE_BITS  current page.
- out_busy  out  1  high from frame start until frame done.
- out_frame_done  out  1  one-cycle pulse at end of frame.
- in_bus_ready  in  1  bus master idle.
- in_bus_next_word  in  1  master has accepted the current byte.
- out_bus_enable  out  1  byte valid / transaction active.
- out_bus_data  out  BUS_BITS  byte to send.

Behaviour:
- Reset (asynchronous, in_rst_n low):
  - state = Reset; all counters, pending flags, latched window and wait timer clear.
  - out_bus_enable = 0, out_bus_data = 0, out_busy = 0, out_frame_done = 0, pixel coordinates = 0.
  - Reset asserted mid-frame aborts immediately; after release the full init sequence is replayed.
- Bus handshake:
  - bus_cycle = in_bus_next_word & ~registered(in_bus_next_word), i.e. its rising edge.
  - out_bus_data is held stable while enabled.
  - Each bus_cycle advances exactly one byte; the next byte is presented with enable still high in the cycle after bus_cycle.
  - Before Idle and before out_frame_done, enable drops and the FSM waits for in_bus_ready = 1.
- Init sequence, 30 bytes in order: 80 AE | 00 D5 F0 | 00 A8 (H-1) | 00 20 00 | 80 A1 | 80 C8 | 00 D3 00 | 00 81 CONTRAST | 80 A6 | 00 8D 14 | 80 AF | 80 A4.
- States: Reset → (WAIT_RESET cycles) → Init/NextInit → Idle → {Setting, FrameCmd, PageCmd, DataCmd, Data/NextData} → Done → Idle.
- Idle dispatch, first match wins:
  1. A pending setting is sent as a 2-byte command: 80 81 is followed by a separate 80 in_contrast; otherwise 80 (A6|invert) or 80 (AE|on).
  2. Otherwise, if an update is pending and the wait timer has reached WAIT_UPDATE, the frame starts.
- Settings pending flags:
  - Set on a set_contrast pulse, or on any change of in_invert or in_disp_on against the last-sent value.
  - Cleared when the setting's last byte is accepted.
- Update request:
  - in_update sets a single pending flag, so at most one request is queued while busy.
  - The flag clears at frame start.
  - The wait timer restarts at frame start.
- Window latch at frame start:
  - x0, x1, p0 and p1 are captured.
  - x1 is clamped to SCREEN_WIDTH-1 and p1 to SCREEN_PAGES-1.
  - If x0 > x1 or p0 > p1 after clamping, the full screen is used.
- Frame, CTRL_TYPE 0:
  - Send 00 21 x0 x1 00 22 p0 p1, then 40, then (x1-x0+1)*(p1-p0+1) data bytes.
  - Column-major within a page, pages ascending.
- Frame, CTRL_TYPE 1:
  - For each page p, send 00 (B0|p) 00 (00|c[3:0]) 00 (10|c[7:4]), then 40, then x1-x0+1 data bytes.
  - c = x0 + COL_OFFS, 8-bit wrap.
- Pixel coordinates:
  - out_hpix/out_vpage point at the byte currently on the bus.
  - in_pixels is sampled combinationally as out_bus_data in Data.
- Counter wrap:
  - At column x1: column returns to x0 and page increments.
  - At page p1 and column x1: Done.
- Done: pulses out_frame_done for one cycle; out_busy falls in the same cycle.
- An in_update arriving in the same cycle as Done is queued and not lost.

Test Plan:
- Power-up with WAIT_RESET=1: exactly 30 bytes equal to the init list; then Idle, out_busy = 0.
- CTRL_TYPE 0, in_update with full window on 128x64: header 00 21 00 7F 00 22 00 07 40; 1024 data bytes; out_frame_done pulse once; out_hpix/out_vpage = 127/7 on the last byte.
- CTRL_TYPE 0, window x0=10 x1=12 p0=2 p1=3: header 00 21 0A 0C 00 22 02 03 40; 6 data bytes in coordinate order (10,2)(11,2)(12,2)(10,3)(11,3)(12,3).
- CTRL_TYPE 1, COL_OFFS=2, window x0=0 x1=1 p0=0 p1=1: per page 00 B0/B1 00 02 00 10 40 followed by 2 bytes; 18 bytes total.
- in_set_contrast=1 with in_contrast=0x33, asserted together with in_update: 80 81 80 33 sent before the frame header. An invalid window x0=20 x1=5 produces a full-screen frame.
- Second in_update and in_invert toggled mid-frame: the frame completes, 80 A7 is sent, then the second frame starts after WAIT_UPDATE. in_rst_n low mid-frame: enable drops asynchronously and init replays.
